// File: rtl/mtl_timing_gen.sv
// LCD raster timing generator: x/y counters, sync/DE decode, pixel-source alignment.
// Latency: lcd_* and sof lag the counters by PIX_LAT+1 pixel strobes.
// Backpressure: none; all state advances only on en (pixel strobe) and holds otherwise.
module mtl_timing_gen #(
    parameter int H_ACT   = 800,
    parameter int H_FP    = 210,
    parameter int H_SYNC  = 30,
    parameter int H_BP    = 16,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 22,
    parameter int V_SYNC  = 13,
    parameter int V_BP    = 10,
    parameter int PIX_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [10:0] x_cnt,
    output logic [9:0]  y_cnt,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b,
    output logic        lcd_hsync_n,
    output logic        lcd_vsync_n,
    output logic        lcd_de,
    output logic        sof
);

    typedef struct packed {
        logic de;
        logic hs_n;
        logic vs_n;
        logic sof;
    } tmg_t;

    localparam tmg_t TMG_IDLE = '{de: 1'b0, hs_n: 1'b1, vs_n: 1'b1, sof: 1'b0};

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACT);
    localparam logic [10:0] X_HS_BEG = 11'(H_ACT + H_FP);
    localparam logic [10:0] X_HS_END = 11'(H_ACT + H_FP + H_SYNC);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_ACT    = 10'(V_ACT);
    localparam logic [9:0]  Y_VS_BEG = 10'(V_ACT + V_FP);
    localparam logic [9:0]  Y_VS_END = 10'(V_ACT + V_FP + V_SYNC);

    tmg_t tmg_raw;
    tmg_t tmg_tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (en) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 10'd1;
            end else begin
                x_cnt <= x_cnt + 11'd1;
            end
        end
    end

    // Vsync is decoded from y alone so it covers the full sync lines.
    always_comb begin
        tmg_raw      = TMG_IDLE;
        tmg_raw.de   = (x_cnt < X_ACT) && (y_cnt < Y_ACT);
        tmg_raw.hs_n = !((x_cnt >= X_HS_BEG) && (x_cnt < X_HS_END));
        tmg_raw.vs_n = !((y_cnt >= Y_VS_BEG) && (y_cnt < Y_VS_END));
        tmg_raw.sof  = (x_cnt == 11'd0) && (y_cnt == 10'd0);
    end

    // Delay matches the pixel source so colour and timing land in the same output stage.
    generate
        if (PIX_LAT == 0) begin : g_no_dly
            assign tmg_tail = tmg_raw;
        end else begin : g_dly
            tmg_t dly [PIX_LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIX_LAT; i++) begin
                        dly[i] <= TMG_IDLE;
                    end
                end else if (en) begin
                    dly[0] <= tmg_raw;
                    for (int i = 1; i < PIX_LAT; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign tmg_tail = dly[PIX_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_de      <= 1'b0;
            lcd_hsync_n <= 1'b1;
            lcd_vsync_n <= 1'b1;
            sof         <= 1'b0;
            lcd_r       <= '0;
            lcd_g       <= '0;
            lcd_b       <= '0;
        end else if (en) begin
            lcd_de      <= tmg_tail.de;
            lcd_hsync_n <= tmg_tail.hs_n;
            lcd_vsync_n <= tmg_tail.vs_n;
            sof         <= tmg_tail.sof;
            lcd_r       <= tmg_tail.de ? red   : 8'd0;
            lcd_g       <= tmg_tail.de ? green : 8'd0;
            lcd_b       <= tmg_tail.de ? blue  : 8'd0;
        end
    end

endmodule

// File: tb/tb_mtl_timing_gen.sv
// Randomized bench for mtl_timing_gen on a small raster, checked against a linear pixel-index model.
module tb_mtl_timing_gen;

    localparam int HA = 12, HF = 3, HS = 4, HB = 2;
    localparam int VA = 6,  VF = 2, VS = 3, VB = 1;
    localparam int LAT = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int N_CYC = 9000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic [7:0]  red, green, blue;
    logic [7:0]  lcd_r, lcd_g, lcd_b;
    logic        lcd_hsync_n, lcd_vsync_n, lcd_de, sof;

    always #5 clk = ~clk;

    mtl_timing_gen #(
        .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_LAT(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .x_cnt(x_cnt),
        .y_cnt(y_cnt),
        .red(red),
        .green(green),
        .blue(blue),
        .lcd_r(lcd_r),
        .lcd_g(lcd_g),
        .lcd_b(lcd_b),
        .lcd_hsync_n(lcd_hsync_n),
        .lcd_vsync_n(lcd_vsync_n),
        .lcd_de(lcd_de),
        .sof(sof)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Colour the pixel source returns for linear pixel index q within a frame.
    function automatic logic [23:0] pix_rgb(input int q);
        int px, py;
        px = q % HT;
        py = q / HT;
        return {8'(px * 7 + py * 3 + 1), 8'(px ^ (py << 4)), 8'(q * 13 + 5)};
    endfunction

    // s counts strobes since the last reset; the counters show pixel s mod FR,
    // and the panel shows pixel s-(LAT+1), or idle if that precedes the reset.
    int s = 0;
    bit armed = 0;
    int cyc_mode;

    task automatic check_outputs();
        int p, q, ex, ey;
        logic e_de, e_hs, e_vs, e_sof;
        logic [23:0] e_rgb;
        p = s % FR;
        check("x_cnt", x_cnt, p % HT);
        check("y_cnt", y_cnt, p / HT);
        e_de = 0; e_hs = 1; e_vs = 1; e_sof = 0; e_rgb = '0;
        if (s >= LAT + 1) begin
            q = (s - LAT - 1) % FR;
            ex = q % HT;
            ey = q / HT;
            e_de  = (ex < HA) && (ey < VA);
            e_hs  = !(ex >= HA + HF && ex < HA + HF + HS);
            e_vs  = !(ey >= VA + VF && ey < VA + VF + VS);
            e_sof = (q == 0);
            e_rgb = e_de ? pix_rgb(q) : 24'd0;
        end
        check("lcd_de", lcd_de, e_de);
        check("lcd_hsync_n", lcd_hsync_n, e_hs);
        check("lcd_vsync_n", lcd_vsync_n, e_vs);
        check("sof", sof, e_sof);
        check("lcd_rgb", {lcd_r, lcd_g, lcd_b}, e_rgb);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        red   = '0;
        green = '0;
        blue  = '0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            if (armed) check_outputs();

            cyc_mode = (cyc / 600) % 3;
            case (cyc_mode)
                0:       en = ($urandom % 4) != 0;
                1:       en = (cyc % 2) == 0;
                default: en = 1'b1;
            endcase
            reset = (cyc < 3) || (cyc == 2500) || (cyc == 5003) || (($urandom % 700) == 0);

            // Garbage on the colour inputs whenever nothing may capture them.
            if (en && s >= LAT)
                {red, green, blue} = pix_rgb((s - LAT) % FR);
            else
                {red, green, blue} = 24'($urandom);

            @(posedge clk);
            if (reset) begin
                s = 0;
                armed = 1;
            end else if (en) begin
                s++;
            end
        end
        @(negedge clk);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtl_timing_gen.md
MTL_TIMING_GEN -- requirements
Module: mtl_timing_gen

Interface
REQ-001 SHALL have parameter H_ACT, default 800, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 210, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 30, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 16, horizontal back porch in pixels; H_TOTAL = sum of the four horizontal parameters = 1056.
REQ-005 SHALL have parameters V_ACT 480, V_FP 22, V_SYNC 13 and V_BP 10, all in lines; V_TOTAL = 525.
REQ-006 SHALL have parameter PIX_LAT, default 1, range 0..4: pixel-source latency in pixel strobes.
REQ-007 SHALL have the one clock port clk, input, 1 bit; all logic is on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port en, input, 1 bit: pixel strobe; state advances only on edges where en=1.
REQ-010 SHALL have port x_cnt, output, 11 bits: current horizontal position, 0..H_TOTAL-1.
REQ-011 SHALL have port y_cnt, output, 10 bits: current vertical position, 0..V_TOTAL-1.
REQ-012 SHALL have ports red, green and blue, input, 8 bits each: pixel colour returned by the source for the (x_cnt, y_cnt) presented PIX_LAT strobes earlier.
REQ-013 SHALL have ports lcd_r, lcd_g and lcd_b, output, 8 bits each: panel colour.
REQ-014 SHALL have ports lcd_hsync_n and lcd_vsync_n, output, 1 bit each: active-low syncs.
REQ-015 SHALL have port lcd_de, output, 1 bit: data enable.
REQ-016 SHALL have port sof, output, 1 bit: start-of-frame marker, aligned with the lcd_* outputs.

Function
REQ-017 x_cnt and y_cnt SHALL be registers; when en=1 and x_cnt=H_TOTAL-1, x_cnt SHALL wrap to 0; otherwise on en=1 it SHALL increment by 1.
REQ-018 y_cnt SHALL increment only on the x_cnt wrap; when it wraps at V_TOTAL-1 it SHALL return to 0 on that same edge.
REQ-019 With en=0, x_cnt, y_cnt, the delay line and all outputs SHALL hold their values.
REQ-020 The raw timing SHALL be derived from the current counters:
- de_raw = (x_cnt < H_ACT) and (y_cnt < V_ACT).
- hs_raw is low for x_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC).
- vs_raw is low for y_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC), for the whole of those lines.
- sof_raw = (x_cnt=0) and (y_cnt=0).
REQ-021 de_raw, hs_raw, vs_raw and sof_raw SHALL pass through a PIX_LAT-stage shift register, advanced on en=1, followed by one output register; total latency SHALL be PIX_LAT+1 strobes.
REQ-022 The red, green and blue inputs SHALL be captured into lcd_r, lcd_g and lcd_b by the output register on en=1, in the same stage as the delayed timing.
REQ-023 When the delayed de is 0, the captured colour SHALL be 0 on all three channels.
REQ-024 Invariant: lcd_* for pixel (x, y) SHALL appear exactly PIX_LAT+1 strobes after x_cnt=x and y_cnt=y were presented.
REQ-025 The pixel source SHALL hold its output stable while en=0; this block imposes no other handshake.
REQ-026 sof SHALL be high for exactly one strobe per frame.
REQ-027 There SHALL be no combinational path from red, green or blue to any output.

Reset
REQ-028 On an edge with reset=1, regardless of en, x_cnt and y_cnt SHALL become 0.
REQ-029 On the same edge, every delay stage SHALL load the inactive values: de=0, hs=1, vs=1, sof=0.
REQ-030 On the same edge, the outputs SHALL become lcd_de=0, lcd_hsync_n=1, lcd_vsync_n=1, sof=0 and lcd_r/g/b=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; the first strobe after release presents x_cnt=0, y_cnt=0, and the outputs stay inactive until the pipeline refills.

Verification
REQ-032 Free run, en=1, defaults:
- lcd_de is high 800 clocks per line and for 480 lines per frame.
- Line period is 1056 clocks; frame period is 554400 clocks.
REQ-033 Sync placement, en=1, defaults:
- lcd_hsync_n is low for 30 clocks, starting 2 clocks after x_cnt=1010.
- lcd_vsync_n is low for 13 full lines, starting with line y=502 (delayed by 2 clocks).
REQ-034 Alignment, PIX_LAT=1, source red = x_cnt[7:0] registered once:
- First lcd_de pixel has lcd_r=0; the 256th has 255; the 800th has 31.
- sof coincides with the first de pixel of the frame.
REQ-035 en toggled 1,0,1,0: counter rate halves; line period is 2112 clocks; REQ-034 alignment still holds.
REQ-036 Reset for one clock at x_cnt=500, y_cnt=100: next x_cnt=0, y_cnt=0; lcd_de stays 0 for 2 strobes, then rises with sof=1.
REQ-037 PIX_LAT=0 and PIX_LAT=4 builds: the alignment of REQ-034 holds with latencies of 1 and 5 strobes respectively.
